// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready and
// emits one bit per clock, with a holding register for gapless streaming.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             load;
  logic             accept;

  // A held word moves into the shifter when idle or on the last bit of the
  // current word, which is what lets consecutive words abut without a gap.
  assign load      = hold_full && (state == IDLE || cnt == LAST);
  assign din_ready = reset && (!hold_full || load);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        sreg  <= hold;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (MSB_FIRST)
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        else
          sreg <= {1'b0, sreg[WIDTH-1:1]};
        if (cnt == LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign out       = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_LEVEL;
  assign out_valid = (state == SHIFT);
  assign out_last  = (state == SHIFT) && (cnt == LAST);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: an MSB-first/idle-0
// instance and an LSB-first/idle-1 instance sharing clock and reset.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       out;
  logic       out_valid;
  logic       out_last;

  logic [7:0] ldin;
  logic       ldin_valid;
  logic       ldin_ready;
  logic       lout;
  logic       lout_valid;
  logic       lout_last;

  int compared;
  int mismatched;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .out(out), .out_valid(out_valid), .out_last(out_last)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .din(ldin), .din_valid(ldin_valid),
    .din_ready(ldin_ready), .out(lout), .out_valid(lout_valid), .out_last(lout_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data);
    din_valid = valid;
    din       = data;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Walks n serial cycles on the selected instance; stream holds the bits in
  // emission order starting from bit n-1.
  task automatic checkStream(input string tag, input logic [15:0] stream, input int n, input bit lsbDut);
    logic [15:0] s;
    s = stream;
    for (int i = 0; i < n; i++) begin
      if (lsbDut) begin
        checkOutput($sformatf("%s_bit%0d", tag, i), {15'd0, lout}, {15'd0, s[n-1-i]});
        checkOutput($sformatf("%s_valid%0d", tag, i), {15'd0, lout_valid}, 16'd1);
        checkOutput($sformatf("%s_last%0d", tag, i), {15'd0, lout_last}, {15'd0, ((i % 8) == 7)});
      end else begin
        checkOutput($sformatf("%s_bit%0d", tag, i), {15'd0, out}, {15'd0, s[n-1-i]});
        checkOutput($sformatf("%s_valid%0d", tag, i), {15'd0, out_valid}, 16'd1);
        checkOutput($sformatf("%s_last%0d", tag, i), {15'd0, out_last}, {15'd0, ((i % 8) == 7)});
      end
      tick();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_out"}, {15'd0, out}, 16'd0);
    checkOutput({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
    checkOutput({tag, "_last"}, {15'd0, out_last}, 16'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    applyStimulus(1'b0, 8'h00);
    ldin       = 8'h00;
    ldin_valid = 1'b0;

    // Reset held low for two edges
    tick();
    tick();
    checkOutput("rst_ready", {15'd0, din_ready}, 16'd0);
    checkIdle("rst");
    checkOutput("rst_lsb_out", {15'd0, lout}, 16'd1);
    checkOutput("rst_lsb_ready", {15'd0, ldin_ready}, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready", {15'd0, din_ready}, 16'd1);

    // Single word A5
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkIdle("a5_pre");
    tick();
    checkStream("a5", 16'b0000000010100101, 8, 1'b0);
    checkIdle("a5_post");

    // Back-to-back A5 then 3C with valid held high
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b1, 8'h3C);
    checkOutput("b2b_ready_loadpend", {15'd0, din_ready}, 16'd1);
    tick();
    applyStimulus(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("b2b_ready%0d", i), {15'd0, din_ready}, {15'd0, (i >= 7)});
      checkOutput($sformatf("b2b_bit%0d", i), {15'd0, out}, {15'd0, ((16'b1010010100111100 >> (15 - i)) & 16'd1) != 16'd0});
      checkOutput($sformatf("b2b_valid%0d", i), {15'd0, out_valid}, 16'd1);
      checkOutput($sformatf("b2b_last%0d", i), {15'd0, out_last}, {15'd0, (i == 7 || i == 15)});
      tick();
    end
    checkIdle("b2b_post");

    // Reset mid-word: FF shifting, 0F held
    applyStimulus(1'b1, 8'hFF);
    tick();
    applyStimulus(1'b1, 8'h0F);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("mid_ready_full", {15'd0, din_ready}, 16'd0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("mid_bit4_out", {15'd0, out}, 16'd1);
    checkOutput("mid_bit4_valid", {15'd0, out_valid}, 16'd1);
    reset = 1'b0;
    tick();
    checkIdle("mid_rst");
    checkOutput("mid_rst_ready", {15'd0, din_ready}, 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_ready", {15'd0, din_ready}, 16'd1);
    tick();
    checkIdle("mid_rel_idle");
    applyStimulus(1'b1, 8'h81);
    tick();
    applyStimulus(1'b0, 8'h00);
    tick();
    checkStream("w81", 16'b0000000010000001, 8, 1'b0);
    checkIdle("w81_post");

    // Recognizer pattern 0101_1101 with idle gaps around it
    tick();
    checkIdle("pat_gap");
    applyStimulus(1'b1, 8'b0101_1101);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkIdle("pat_pre");
    tick();
    checkStream("pat", 16'b0000000001011101, 8, 1'b0);
    checkIdle("pat_post");

    // LSB-first instance idles high and emits din[0] first
    checkOutput("lsb_idle", {15'd0, lout}, 16'd1);
    ldin       = 8'h01;
    ldin_valid = 1'b1;
    tick();
    ldin_valid = 1'b0;
    checkOutput("lsb_pre_out", {15'd0, lout}, 16'd1);
    checkOutput("lsb_pre_valid", {15'd0, lout_valid}, 16'd0);
    tick();
    checkStream("lsb01", 16'b0000000010000000, 8, 1'b1);
    checkOutput("lsb_post_out", {15'd0, lout}, 16'd1);
    checkOutput("lsb_post_valid", {15'd0, lout_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
